// File: rtl/led_cmd_ctrl.sv
// rtl/led_cmd_ctrl.sv - SPI command controller: LED brightness registers, readback staging, PWM outputs
// Optional feature macro: LED_GAMMA_EN (square-law duty mapping).

`ifndef CMD_BITS
`define CMD_BITS 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 8
`endif
`ifndef PAYLOAD_BITS
`define PAYLOAD_BITS 8
`endif
`ifndef MASTER_FRAME_WIDTH
`define MASTER_FRAME_WIDTH 24
`endif
`ifndef CS_ASSERT
`define CS_ASSERT 1'b0
`endif
`ifndef CS_DEASSERT
`define CS_DEASSERT 1'b1
`endif
`ifndef CMD_NOP
`define CMD_NOP 8'h00
`endif
`ifndef CMD_WRITE
`define CMD_WRITE 8'h01
`endif
`ifndef CMD_READ
`define CMD_READ 8'h02
`endif

module led_cmd_ctrl #(
    parameter int NUM_LEDS  = 4,
    parameter int PWM_DIV   = 1250,
    parameter int PWM_STEPS = 100
) (
    input  logic                           sysclk,
    input  logic                           rst,
    input  logic                           cs,
    input  logic [`CMD_BITS-1:0]           i_cmd,
    input  logic [`ADDR_BITS-1:0]          i_addr,
    input  logic [`PAYLOAD_BITS-1:0]       i_payload,
    output logic                           o_slv_tx_enb,
    output logic [`MASTER_FRAME_WIDTH-1:0] o_slv_frame,
    output logic [NUM_LEDS-1:0]            o_led,
    output logic                           o_err
);

    localparam int IDX_W  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int DIV_W  = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int STEP_W = (PWM_STEPS > 1) ? $clog2(PWM_STEPS) : 1;
    localparam int BR_W   = 7;

    typedef enum logic [1:0] {ARMED, EXEC, WAIT_CS} frame_state_t;
    typedef enum logic [1:0] {R_NONE, R_PEND, R_SEND} resp_state_t;

    frame_state_t fstate, fstate_n;
    resp_state_t  rstate, rstate_n;

    logic [`CMD_BITS-1:0]     cmd_q;
    logic [`ADDR_BITS-1:0]    addr_q;
    logic [`PAYLOAD_BITS-1:0] payload_q;
    logic                     rearm_ok;
    logic                     pend_idle;
    logic                     latch_en;
    logic                     exec_en;

    logic [BR_W-1:0]   bright [NUM_LEDS];
    logic [BR_W-1:0]   duty   [NUM_LEDS];
    logic [DIV_W-1:0]  presc;
    logic [STEP_W-1:0] step;

    logic                     is_write;
    logic                     is_read;
    logic                     addr_ok;
    logic [IDX_W-1:0]         addr_idx;
    logic [BR_W-1:0]          wr_value;
    logic [`PAYLOAD_BITS-1:0] rd_payload;

    function automatic logic [BR_W-1:0] duty_map(input logic [BR_W-1:0] b);
`ifdef LED_GAMMA_EN
        logic [13:0] sq;
        sq = {7'd0, b} * {7'd0, b};
        return BR_W'(sq / 14'd100);
`else
        return b;
`endif
    endfunction

    assign is_write   = (cmd_q == `CMD_WRITE);
    assign is_read    = (cmd_q == `CMD_READ);
    assign addr_ok    = (addr_q < `ADDR_BITS'(NUM_LEDS));
    assign addr_idx   = addr_q[IDX_W-1:0];
    assign wr_value   = (payload_q > `PAYLOAD_BITS'(100)) ? BR_W'(100) : payload_q[BR_W-1:0];
    assign rd_payload = addr_ok ? `PAYLOAD_BITS'(bright[addr_idx]) : '1;

    always_ff @(posedge sysclk) begin
        if (rst) begin
            fstate <= ARMED;
            rstate <= R_NONE;
        end else begin
            fstate <= fstate_n;
            rstate <= rstate_n;
        end
    end

    // rearm_ok blocks a frame that was already in flight when reset hit.
    always_comb begin
        fstate_n = fstate;
        latch_en = 1'b0;
        exec_en  = 1'b0;
        case (fstate)
            ARMED: begin
                if (rearm_ok && cs == `CS_ASSERT && i_cmd != `CMD_NOP) begin
                    latch_en = 1'b1;
                    fstate_n = EXEC;
                end
            end
            EXEC: begin
                exec_en  = 1'b1;
                fstate_n = WAIT_CS;
            end
            WAIT_CS: begin
                if (cs == `CS_DEASSERT) fstate_n = ARMED;
            end
            default: fstate_n = ARMED;
        endcase
    end

    always_comb begin
        rstate_n = rstate;
        case (rstate)
            R_NONE: rstate_n = R_NONE;
            R_PEND: if (pend_idle && cs == `CS_ASSERT) rstate_n = R_SEND;
            R_SEND: if (cs == `CS_DEASSERT) rstate_n = R_NONE;
            default: rstate_n = R_NONE;
        endcase
        if (exec_en && is_read) rstate_n = R_PEND;
    end

    assign o_slv_tx_enb = (rstate != R_NONE);

    always_ff @(posedge sysclk) begin
        if (rst) begin
            cmd_q       <= '0;
            addr_q      <= '0;
            payload_q   <= '0;
            rearm_ok    <= 1'b0;
            pend_idle   <= 1'b0;
            o_err       <= 1'b0;
            o_slv_frame <= '0;
            for (int i = 0; i < NUM_LEDS; i++) bright[i] <= '0;
        end else begin
            if (cs == `CS_DEASSERT) rearm_ok <= 1'b1;
            if (latch_en) begin
                cmd_q     <= i_cmd;
                addr_q    <= i_addr;
                payload_q <= i_payload;
            end
            if (exec_en) begin
                if (is_write && addr_ok) bright[addr_idx] <= wr_value;
                if (!(is_write || is_read) || !addr_ok) o_err <= 1'b1;
            end
            if (exec_en && is_read) begin
                o_slv_frame <= {`CMD_READ, addr_q, rd_payload};
                pend_idle   <= 1'b0;
            end else begin
                if (rstate == R_PEND && cs == `CS_DEASSERT) pend_idle <= 1'b1;
                if (rstate == R_SEND && cs == `CS_DEASSERT) o_slv_frame <= '0;
            end
        end
    end

    // Duty reloads only at the period boundary so a period is never cut short.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            presc <= '0;
            step  <= '0;
            o_led <= '0;
            for (int i = 0; i < NUM_LEDS; i++) duty[i] <= '0;
        end else begin
            if (presc == DIV_W'(PWM_DIV - 1)) begin
                presc <= '0;
                if (step == STEP_W'(PWM_STEPS - 1)) begin
                    step <= '0;
                    for (int i = 0; i < NUM_LEDS; i++) duty[i] <= duty_map(bright[i]);
                end else begin
                    step <= step + 1'b1;
                end
            end else begin
                presc <= presc + 1'b1;
            end
            for (int i = 0; i < NUM_LEDS; i++) o_led[i] <= (32'(step) < 32'(duty[i]));
        end
    end

endmodule

// File: tb/tb_led_cmd_ctrl.sv
// tb/tb_led_cmd_ctrl.sv - directed self-checking bench for led_cmd_ctrl

module tb_led_cmd_ctrl;

    localparam int NUM_LEDS  = 4;
    localparam int PWM_DIV   = 4;
    localparam int PWM_STEPS = 100;
    localparam int PERIOD    = PWM_DIV * PWM_STEPS;

`ifdef LED_GAMMA_EN
    localparam int EXP50 = 100;
    localparam int EXP37 = 52;
    localparam int EXP10 = 4;
`else
    localparam int EXP50 = 200;
    localparam int EXP37 = 148;
    localparam int EXP10 = 40;
`endif

    logic        sysclk = 1'b0;
    logic        rst;
    logic        cs;
    logic [7:0]  i_cmd;
    logic [7:0]  i_addr;
    logic [7:0]  i_payload;
    logic        o_slv_tx_enb;
    logic [23:0] o_slv_frame;
    logic [3:0]  o_led;
    logic        o_err;

    int n_checks = 0;
    int n_pass   = 0;
    int hi_cnt [4];

    always #4 sysclk = ~sysclk;

    led_cmd_ctrl #(
        .NUM_LEDS  (NUM_LEDS),
        .PWM_DIV   (PWM_DIV),
        .PWM_STEPS (PWM_STEPS)
    ) dut (
        .sysclk       (sysclk),
        .rst          (rst),
        .cs           (cs),
        .i_cmd        (i_cmd),
        .i_addr       (i_addr),
        .i_payload    (i_payload),
        .o_slv_tx_enb (o_slv_tx_enb),
        .o_slv_frame  (o_slv_frame),
        .o_led        (o_led),
        .o_err        (o_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] p, input int hold);
        cs = 1'b0;
        cycles(2);
        i_cmd = c;
        i_addr = a;
        i_payload = p;
        cycles(hold);
        cs = 1'b1;
        i_cmd = 8'h00;
        i_addr = 8'h00;
        i_payload = 8'h00;
        cycles(3);
    endtask

    task automatic count_high();
        for (int i = 0; i < 4; i++) hi_cnt[i] = 0;
        repeat (PERIOD) begin
            @(negedge sysclk);
            for (int i = 0; i < 4; i++) if (o_led[i]) hi_cnt[i]++;
        end
        cycles(1);
    endtask

    initial begin
        rst = 1'b1;
        cs = 1'b1;
        i_cmd = 8'h00;
        i_addr = 8'h00;
        i_payload = 8'h00;
        cycles(5);
        rst = 1'b0;
        cycles(2);
        @(negedge sysclk);
        check("rst_led", 32'(o_led), 32'h0);
        check("rst_tx", 32'(o_slv_tx_enb), 32'h0);
        check("rst_frame", 32'(o_slv_frame), 32'h0);
        check("rst_err", 32'(o_err), 32'h0);
        cycles(1);

        send_frame(8'h01, 8'd1, 8'd50, 4);
        cycles(2 * PERIOD + 10);
        count_high();
        check("led1_50", 32'(hi_cnt[1]), 32'(EXP50));
        check("led0_off", 32'(hi_cnt[0]), 32'h0);
        check("led2_off", 32'(hi_cnt[2]), 32'h0);
        check("led3_off", 32'(hi_cnt[3]), 32'h0);

        send_frame(8'h01, 8'd0, 8'd200, 4);
        cycles(2 * PERIOD + 10);
        count_high();
        check("led0_sat", 32'(hi_cnt[0]), 32'(PERIOD));
        send_frame(8'h01, 8'd0, 8'd0, 4);
        cycles(2 * PERIOD + 10);
        count_high();
        check("led0_zero", 32'(hi_cnt[0]), 32'h0);

        send_frame(8'h01, 8'd2, 8'd37, 4);
        send_frame(8'h02, 8'd2, 8'd0, 4);
        @(negedge sysclk);
        check("rd2_frame", 32'(o_slv_frame), 32'h020225);
        check("rd2_tx", 32'(o_slv_tx_enb), 32'h1);
        cycles(1);
        cs = 1'b0;
        cycles(4);
        @(negedge sysclk);
        check("rd2_hold_frame", 32'(o_slv_frame), 32'h020225);
        check("rd2_hold_tx", 32'(o_slv_tx_enb), 32'h1);
        cycles(1);
        cs = 1'b1;
        cycles(2);
        @(negedge sysclk);
        check("rd2_done_frame", 32'(o_slv_frame), 32'h0);
        check("rd2_done_tx", 32'(o_slv_tx_enb), 32'h0);
        cycles(1);

        send_frame(8'h02, 8'd1, 8'd0, 4);
        send_frame(8'h02, 8'd2, 8'd0, 4);
        @(negedge sysclk);
        check("rd_in_send_frame", 32'(o_slv_frame), 32'h020225);
        check("rd_in_send_tx", 32'(o_slv_tx_enb), 32'h1);
        cycles(1);
        send_frame(8'h00, 8'd0, 8'd0, 4);
        @(negedge sysclk);
        check("rd_in_send_done", 32'(o_slv_tx_enb), 32'h0);
        check("err_clean", 32'(o_err), 32'h0);
        cycles(1);

        send_frame(8'h02, 8'd9, 8'd0, 4);
        @(negedge sysclk);
        check("rd9_frame", 32'(o_slv_frame), 32'h0209FF);
        check("rd9_err", 32'(o_err), 32'h1);
        cycles(1);
        send_frame(8'h00, 8'd0, 8'd0, 4);
        send_frame(8'h01, 8'd9, 8'd50, 4);
        cycles(2 * PERIOD + 10);
        count_high();
        check("wr9_led0", 32'(hi_cnt[0]), 32'h0);
        check("wr9_led1", 32'(hi_cnt[1]), 32'(EXP50));
        check("wr9_led2", 32'(hi_cnt[2]), 32'(EXP37));
        check("wr9_led3", 32'(hi_cnt[3]), 32'h0);

        send_frame(8'h01, 8'd3, 8'd10, 500);
        send_frame(8'h02, 8'd3, 8'd0, 4);
        @(negedge sysclk);
        check("rd3_frame", 32'(o_slv_frame), 32'h02030A);
        cycles(1);
        send_frame(8'h00, 8'd0, 8'd0, 4);
        cycles(2 * PERIOD + 10);
        count_high();
        check("led3_10", 32'(hi_cnt[3]), 32'(EXP10));

        cs = 1'b0;
        cycles(2);
        i_cmd = 8'h01;
        i_addr = 8'd3;
        i_payload = 8'd100;
        rst = 1'b1;
        cycles(2);
        @(negedge sysclk);
        check("midrst_led", 32'(o_led), 32'h0);
        check("midrst_err", 32'(o_err), 32'h0);
        check("midrst_tx", 32'(o_slv_tx_enb), 32'h0);
        cycles(1);
        rst = 1'b0;
        cycles(50);
        cs = 1'b1;
        i_cmd = 8'h00;
        i_addr = 8'h00;
        i_payload = 8'h00;
        cycles(3);
        send_frame(8'h02, 8'd3, 8'd0, 4);
        @(negedge sysclk);
        check("midrst_rd3", 32'(o_slv_frame), 32'h020300);
        cycles(1);
        send_frame(8'h00, 8'd0, 8'd0, 4);

`ifdef LED_GAMMA_EN
        send_frame(8'h01, 8'd3, 8'd50, 4);
        cycles(2 * PERIOD + 10);
        count_high();
        check("gamma_led3", 32'(hi_cnt[3]), 32'(25 * PWM_DIV));
        send_frame(8'h02, 8'd3, 8'd0, 4);
        @(negedge sysclk);
        check("gamma_rd3", 32'(o_slv_frame), 32'h020332);
        cycles(1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
